// File: rtl/instr_loader.sv
// Assembles a big-endian byte stream into 32-bit words and writes them to instruction memory, holding the CPU meanwhile.
// Write strobe follows the word-completing byte by one cycle; in_ready drops during that write cycle and stays low once done.
module instr_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          DEPTH     = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [7:0]             in_byte,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic [$clog2(DEPTH):0] word_count,
  output logic                   overflow,
  output logic                   partial
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {ASSEMBLE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     buf_q, buf_d;
  logic            last_q, last_d;
  logic [CW-1:0]   wc_q, wc_d;
  logic            ovf_q, ovf_d;
  logic            part_q, part_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            accept;
  logic            word_end;
  logic            full;
  logic [31:0]     word_nxt;

  assign accept   = in_valid && in_ready;
  assign word_end = accept && ((idx_q == 2'd3) || in_last);
  assign full     = (wc_q == CW'(DEPTH));
  // Byte k lands at [31-8k:24-8k]; the buffer is zero beyond the filled bytes.
  assign word_nxt = buf_q | ({in_byte, 24'h000000} >> {idx_q, 3'b000});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ASSEMBLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ASSEMBLE: if (word_end) state_d = WRITE;
      WRITE:    state_d = last_q ? DONE : ASSEMBLE;
      DONE:     state_d = DONE;
      default:  state_d = ASSEMBLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ASSEMBLE) && !reset;
    // A reset landing on the write cycle must not corrupt memory.
    imem_we  = (state_q == WRITE) && !full && !reset;
    cpu_hold = (state_q != DONE);
    done     = (state_q == DONE);
  end

  always_comb begin
    idx_d   = idx_q;
    buf_d   = buf_q;
    last_d  = last_q;
    wc_d    = wc_q;
    ovf_d   = ovf_q;
    part_d  = part_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ASSEMBLE: begin
        if (accept) begin
          buf_d = word_nxt;
          idx_d = idx_q + 2'd1;
        end
        if (word_end) begin
          last_d = in_last;
          if (in_last && (idx_q != 2'd3)) part_d = 1'b1;
          // Address/data are captured at word completion so they hold after the strobe.
          if (!full) begin
            addr_d  = BASE_ADDR + (32'(wc_q) << 2);
            wdata_d = word_nxt;
          end
        end
      end
      WRITE: begin
        buf_d = 32'd0;
        idx_d = 2'd0;
        if (full) ovf_d = 1'b1;
        else      wc_d  = wc_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      buf_q   <= 32'd0;
      last_q  <= 1'b0;
      wc_q    <= '0;
      ovf_q   <= 1'b0;
      part_q  <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
      wc_q    <= wc_d;
      ovf_q   <= ovf_d;
      part_q  <= part_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  assign overflow   = ovf_q;
  assign partial    = part_q;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Parameters
REQ-001 BASE_ADDR, default 32'd0, byte address of the first instruction word written.
REQ-002 DEPTH, default 256, instruction-memory capacity in 32-bit words.

Interface
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_byte  input  8  program byte, MIPS big-endian order (first byte is instr[31:24]).
REQ-007 in_last  input  1  marks the final byte of the program; qualified by in_valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 imem_addr  output  32  word-aligned byte address of the write (BASE_ADDR + 4*index).
REQ-011 imem_wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  holds the processor (PC and register writes) until load completes.
REQ-013 done  output  1  program fully written.
REQ-014 word_count  output  $clog2(DEPTH)+1  number of words committed to memory.
REQ-015 overflow  output  1  sticky; program exceeded DEPTH words.
REQ-016 partial  output  1  sticky; in_last arrived on a non-word boundary.

Function
REQ-017 The FSM SHALL have states ASSEMBLE, WRITE, DONE.
REQ-018 A byte is transferred only on a cycle where in_valid && in_ready.
REQ-019 in_ready SHALL be 1 in ASSEMBLE, 0 in WRITE and DONE.
REQ-020 In ASSEMBLE, byte k (k = 0..3 within the word) SHALL land in bits [31-8k:24-8k] of the shift buffer.
REQ-021 On the 4th accepted byte, or on any accepted byte with in_last=1, the FSM SHALL move to WRITE.
REQ-022 On in_last at byte k<3, the unfilled low bytes SHALL be zero, and partial SHALL set.
REQ-023 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*word_count and imem_wdata = the assembled word.
REQ-024 After WRITE, word_count SHALL increment by 1, and the byte index and buffer SHALL clear.
REQ-025 After WRITE, the next state SHALL be DONE if the word carried in_last, otherwise ASSEMBLE.
REQ-026 Byte-to-write latency SHALL be 1 cycle: imem_we is asserted in the cycle after the 4th byte is accepted.
REQ-027 Sustained throughput SHALL be 4 bytes per 5 cycles.
REQ-028 If word_count == DEPTH on entering WRITE, imem_we SHALL stay 0, overflow SHALL set, and word_count SHALL saturate at DEPTH.
REQ-029 Under overflow, bytes SHALL still be consumed until in_last.
REQ-030 cpu_hold SHALL be 1 in every state except DONE.
REQ-031 done SHALL be 1 only in DONE.
REQ-032 DONE SHALL be terminal until reset; in_valid is ignored there.
REQ-033 imem_addr and imem_wdata SHALL hold their last written values when imem_we=0.
REQ-034 in_valid with in_last=0 while in_ready=0 SHALL NOT alter state (the producer must hold the byte).

Reset
REQ-035 On reset=1 at a clock edge, the FSM SHALL enter ASSEMBLE, from any state, including mid-word or mid-WRITE.
REQ-036 Reset SHALL produce: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, overflow=0, partial=0, done=0, cpu_hold=1, in_ready=0, and clear the byte index and buffer.
REQ-037 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-038 A reset asserted in the same cycle as a WRITE SHALL suppress that write.

Verification
REQ-039 Stream bytes 20 01 00 05 with in_last on the final byte -> one write, addr 0, data 32'h20010005; done=1 and cpu_hold=0 on the next cycle; word_count=1.
REQ-040 Stream 12 back-to-back bytes with in_valid held high, last on byte 12 -> writes to addrs 0, 4, 8; in_ready low exactly on each WRITE cycle; no byte lost.
REQ-041 Stream bytes AA BB with in_last on BB -> write data 32'hAABB0000; partial=1; done=1.
REQ-042 DEPTH=2, stream 12 bytes -> only addrs 0 and 4 written; overflow=1; word_count=2; done after the 12th byte.
REQ-043 Assert reset after 2 bytes of the second word -> all outputs at reset values; then stream 4 new bytes -> the write goes to addr BASE_ADDR.
REQ-044 BASE_ADDR=32'd1024, stream 8 bytes -> writes at 1024 and 1028.
